// File: rtl/multi_channel_variant_scheduler_if.sv
// ============================================================================
// Module  : multi_channel_variant_scheduler_if
// Purpose : FIFO-side and beat-side signal bundle for the variant scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multi_channel_variant_scheduler_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int VARIANTS     = 2,
    parameter int BOT_WIDTH    = 128,
    parameter int INDEX_WIDTH  = 12,
    parameter int DEPTH_LOG2   = 5
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int VW = (VARIANTS > 1) ? $clog2(VARIANTS) : 1;
    localparam int EW = BOT_WIDTH + INDEX_WIDTH + VARIANTS;

    logic [NUM_CHANNELS-1:0]            fifoEmpty;
    logic [NUM_CHANNELS*DEPTH_LOG2-1:0] fifoUsedw;
    logic [NUM_CHANNELS*EW-1:0]         fifoData;
    logic [NUM_CHANNELS-1:0]            fifoPop;
    logic                               almostFull;
    logic                               outReady;
    logic                               outValid;
    logic [BOT_WIDTH-1:0]               botOut;
    logic [INDEX_WIDTH-1:0]             botOutIndex;
    logic [CW+VW-1:0]                   botOutSubIndex;

    modport master (
        output fifoEmpty, fifoUsedw, fifoData, outReady,
        input  fifoPop, almostFull, outValid, botOut, botOutIndex, botOutSubIndex
    );

    modport slave (
        input  fifoEmpty, fifoUsedw, fifoData, outReady,
        output fifoPop, almostFull, outValid, botOut, botOutIndex, botOutSubIndex
    );
endinterface

`default_nettype wire

// File: rtl/multi_channel_variant_scheduler.sv
// ============================================================================
// Module  : multi_channel_variant_scheduler
// Purpose : Picks one FIFO head per grab (fullest / starvation guard) and
//           expands it into one output beat per set variant-mask bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_channel_variant_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int VARIANTS     = 2,
    parameter int BOT_WIDTH    = 128,
    parameter int INDEX_WIDTH  = 12,
    parameter int DEPTH_LOG2   = 5,
    parameter int ALMOST_FULL  = 28,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    multi_channel_variant_scheduler_if.slave bus
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int VW = (VARIANTS > 1) ? $clog2(VARIANTS) : 1;
    localparam int EW = BOT_WIDTH + INDEX_WIDTH + VARIANTS;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [BOT_WIDTH-1:0]   cur_bot_q,     cur_bot_d;
    logic [INDEX_WIDTH-1:0] cur_index_q,   cur_index_d;
    logic [CW-1:0]          cur_channel_q, cur_channel_d;
    logic [VARIANTS-1:0]    rem_mask_q,    rem_mask_d;
    logic [CW-1:0]          rr_ptr_q,      rr_ptr_d;
    logic [WW-1:0]          wait_cnt_q [NUM_CHANNELS];
    logic [WW-1:0]          wait_cnt_d [NUM_CHANNELS];

    logic [DEPTH_LOG2-1:0]  used [NUM_CHANNELS];
    logic [CW-1:0]          sel;
    logic                   starve_hit;
    logic                   have_best;
    logic [DEPTH_LOG2-1:0]  best_used;
    logic [CW:0]            scan_sum;
    logic [CW-1:0]          scan_ch;
    logic [EW-1:0]          head;
    logic                   out_valid;
    logic                   one_left;
    logic                   load;
    logic                   grab;
    logic [VW-1:0]          low_idx;
    logic                   almost_full;

    always_comb begin
        almost_full = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            used[c]     = bus.fifoUsedw[c*DEPTH_LOG2 +: DEPTH_LOG2];
            almost_full = almost_full | (used[c] >= DEPTH_LOG2'(ALMOST_FULL));
        end
    end

    // Starved channels win outright; otherwise fullest, ties resolved by a circular scan from rr_ptr.
    always_comb begin
        sel        = '0;
        starve_hit = 1'b0;
        have_best  = 1'b0;
        best_used  = '0;
        scan_sum   = '0;
        scan_ch    = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (!bus.fifoEmpty[c] && (wait_cnt_q[c] >= WW'(STARVE_LIMIT))) begin
                starve_hit = 1'b1;
                sel        = CW'(c);
            end
        end
        if (!starve_hit) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
                if (scan_sum >= (CW+1)'(NUM_CHANNELS)) begin
                    scan_sum = scan_sum - (CW+1)'(NUM_CHANNELS);
                end
                scan_ch = scan_sum[CW-1:0];
                if (!bus.fifoEmpty[scan_ch] && (!have_best || (used[scan_ch] > best_used))) begin
                    have_best = 1'b1;
                    best_used = used[scan_ch];
                    sel       = scan_ch;
                end
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int v = VARIANTS - 1; v >= 0; v--) begin
            if (rem_mask_q[v]) begin
                low_idx = VW'(v);
            end
        end
    end

    assign head      = bus.fifoData[sel*EW +: EW];
    assign out_valid = |rem_mask_q;
    assign one_left  = out_valid && ((rem_mask_q & (rem_mask_q - VARIANTS'(1))) == '0);
    assign load      = !out_valid || (bus.outReady && one_left);
    assign grab      = load && (|(~bus.fifoEmpty));

    always_comb begin
        cur_bot_d     = cur_bot_q;
        cur_index_d   = cur_index_q;
        cur_channel_d = cur_channel_q;
        rem_mask_d    = rem_mask_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        if (grab) begin
            cur_bot_d     = head[EW-1 -: BOT_WIDTH];
            cur_index_d   = head[VARIANTS +: INDEX_WIDTH];
            cur_channel_d = sel;
            rem_mask_d    = head[VARIANTS-1:0];
            rr_ptr_d      = (sel == CW'(NUM_CHANNELS - 1)) ? '0 : sel + CW'(1);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if ((CW'(c) == sel) || bus.fifoEmpty[c]) begin
                    wait_cnt_d[c] = '0;
                end else if (wait_cnt_q[c] < WW'(STARVE_LIMIT)) begin
                    wait_cnt_d[c] = wait_cnt_q[c] + WW'(1);
                end
            end
        end else if (load) begin
            rem_mask_d = '0;
        end else if (bus.outReady) begin
            rem_mask_d = rem_mask_q & (rem_mask_q - VARIANTS'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_bot_q     <= '0;
            cur_index_q   <= '0;
            cur_channel_q <= '0;
            rem_mask_q    <= '0;
            rr_ptr_q      <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wait_cnt_q[c] <= '0;
            end
        end else begin
            cur_bot_q     <= cur_bot_d;
            cur_index_q   <= cur_index_d;
            cur_channel_q <= cur_channel_d;
            rem_mask_q    <= rem_mask_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Pop is gated by reset directly so an asserted reset suppresses it within the same cycle.
    assign bus.fifoPop        = (grab && rst) ? (NUM_CHANNELS'(1) << sel) : '0;
    assign bus.almostFull     = almost_full;
    assign bus.outValid       = out_valid;
    assign bus.botOut         = cur_bot_q;
    assign bus.botOutIndex    = cur_index_q;
    assign bus.botOutSubIndex = {cur_channel_q, low_idx};
endmodule

`default_nettype wire

// File: tb/tb_multi_channel_variant_scheduler.sv
// ============================================================================
// Module  : tb_multi_channel_variant_scheduler
// Purpose : Random FIFO traffic against a queue-based reference scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_channel_variant_scheduler;
    localparam int NC = 4;
    localparam int NV = 2;
    localparam int BW = 128;
    localparam int IW = 12;
    localparam int DL = 5;
    localparam int AF = 28;
    localparam int SL = 4;
    localparam int CW = 2;
    localparam int VW = 1;
    localparam int EW = BW + IW + NV;
    localparam int QMAX = 31;

    typedef logic [EW-1:0] ent_t;
    typedef logic [BW+IW+CW+VW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_channel_variant_scheduler_if #(
        .NUM_CHANNELS(NC), .VARIANTS(NV), .BOT_WIDTH(BW), .INDEX_WIDTH(IW), .DEPTH_LOG2(DL)
    ) bus ();

    multi_channel_variant_scheduler #(
        .NUM_CHANNELS(NC), .VARIANTS(NV), .BOT_WIDTH(BW), .INDEX_WIDTH(IW),
        .DEPTH_LOG2(DL), .ALMOST_FULL(AF), .STARVE_LIMIT(SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t  fq [NC][$];
    beat_t sb [$];
    int    wait_m [NC];
    int    rr_m;
    int    cur_beats;
    int    checks;
    int    errors;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t rand_ent(input logic [NV-1:0] mask);
        logic [BW-1:0] b;
        logic [IW-1:0] ix;
        b  = {$urandom, $urandom, $urandom, $urandom};
        ix = IW'($urandom);
        return {b, ix, mask};
    endfunction

    task automatic drive();
        for (int c = 0; c < NC; c++) begin
            bus.fifoEmpty[c]            = (fq[c].size() == 0);
            bus.fifoUsedw[c*DL +: DL]   = DL'(fq[c].size());
            bus.fifoData[c*EW +: EW]    = (fq[c].size() > 0) ? fq[c][0] : '0;
        end
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NC; c++) if (fq[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        cur_beats = 0;
        rr_m      = 0;
        for (int c = 0; c < NC; c++) wait_m[c] = 0;
        sb.delete();
    endtask

    // Reference scheduler: advances one cycle using the values visible before the edge.
    task automatic model_step(output int pop_ch);
        logic [NC-1:0] exp_pop;
        bit load, any, af;
        int sel, best, c;
        ent_t h;
        af  = 1'b0;
        any = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (fq[i].size() >= AF) af = 1'b1;
            if (fq[i].size() > 0) any = 1'b1;
        end
        check("out_valid", bus.outValid, cur_beats > 0);
        check("almost_full", bus.almostFull, af);
        load    = (cur_beats == 0) || (bus.outReady && cur_beats == 1);
        exp_pop = '0;
        pop_ch  = -1;
        if (load && any) begin
            sel = -1;
            for (int i = 0; i < NC; i++)
                if (sel < 0 && fq[i].size() > 0 && wait_m[i] >= SL) sel = i;
            if (sel < 0) begin
                best = -1;
                for (int k = 0; k < NC; k++) begin
                    c = (rr_m + k) % NC;
                    if (fq[c].size() > best && fq[c].size() > 0) begin
                        sel  = c;
                        best = fq[c].size();
                    end
                end
            end
            h = fq[sel][0];
            cur_beats = 0;
            for (int v = 0; v < NV; v++) begin
                if (h[v]) begin
                    sb.push_back({h[EW-1 -: BW], h[NV +: IW], CW'(sel), VW'(v)});
                    cur_beats++;
                end
            end
            for (int i = 0; i < NC; i++)
                wait_m[i] = (i == sel || fq[i].size() == 0) ? 0 : ((wait_m[i] + 1 > SL) ? SL : wait_m[i] + 1);
            rr_m         = (sel + 1) % NC;
            exp_pop[sel] = 1'b1;
            pop_ch       = sel;
        end else if (load) begin
            cur_beats = 0;
        end else if (bus.outReady) begin
            cur_beats--;
        end
        check("fifo_pop", bus.fifoPop, exp_pop);
    endtask

    task automatic cycle(input int push_pct, input int ready_pct);
        int pc, c;
        @(negedge clk);
        model_step(pc);
        @(posedge clk);
        #1;
        if (pc >= 0) void'(fq[pc].pop_front());
        if ($urandom_range(99) < push_pct) begin
            c = $urandom_range(NC - 1);
            if (fq[c].size() < QMAX) fq[c].push_back(rand_ent(NV'($urandom)));
        end
        bus.outReady = ($urandom_range(99) < ready_pct);
        drive();
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 3000 && !(all_empty() && cur_beats == 0)) begin
            cycle(0, 100);
            i++;
        end
        check("drain_done", (all_empty() && cur_beats == 0), 1);
    endtask

    // Scoreboard side: pops one expected beat for every accepted beat.
    logic  prev_hold;
    beat_t prev_beat;
    initial begin
        prev_hold = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && bus.outValid)
                    check("stall_stable", {bus.botOut, bus.botOutIndex, bus.botOutSubIndex}, prev_beat);
                if (bus.outValid && bus.outReady) begin
                    if (sb.size() == 0) begin
                        check("beat_unexpected", 1, 0);
                    end else begin
                        check("beat", {bus.botOut, bus.botOutIndex, bus.botOutSubIndex}, sb.pop_front());
                    end
                end
                prev_hold = bus.outValid && !bus.outReady;
                prev_beat = {bus.botOut, bus.botOutIndex, bus.botOutSubIndex};
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        model_reset();
        bus.outReady = 1'b0;
        fq[0].push_back(rand_ent(2'b11));
        fq[2].push_back(rand_ent(2'b01));
        drive();
        repeat (3) begin
            @(negedge clk);
            check("reset_valid", bus.outValid, 0);
            check("reset_pop", bus.fifoPop, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.outReady = 1'b1;

        repeat (1500) cycle(60, 60);
        repeat (12) cycle(30, 0);
        repeat (200) cycle(50, 80);
        drain();

        for (int c = 0; c < NC; c++) begin
            n = (c == NC - 1) ? 1 : 20;
            for (int i = 0; i < n; i++) fq[c].push_back(rand_ent(NV'($urandom)));
        end
        drive();
        repeat (40) cycle(0, 100);
        drain();

        for (int i = 0; i < 4; i++) fq[1].push_back(rand_ent(2'b11));
        drive();
        n = 0;
        while (n < 50 && cur_beats != 1) begin
            cycle(0, 100);
            n++;
        end
        check("mid_entry_reached", cur_beats, 1);
        rst = 1'b0;
        #1;
        check("async_reset_valid", bus.outValid, 0);
        check("async_reset_pop", bus.fifoPop, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("held_reset_pop", bus.fifoPop, 0);
        rst = 1'b1;

        repeat (800) cycle(50, 70);
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
